// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states,
// parity/stop format codes and the stop-phase length in sample ticks.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [1:0] STOP_1   = 2'b00;
   localparam logic [1:0] STOP_1P5 = 2'b01;
   localparam logic [1:0] STOP_2   = 2'b10;

   // Reserved code 11 falls back to a single stop bit.
   function automatic int stop_ticks(input logic [1:0] stop, input int oversample);
      case (stop)
         STOP_1:   return oversample;
         STOP_1P5: return (3 * oversample) / 2;
         STOP_2:   return 2 * oversample;
         default:  return oversample;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_cfg_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push while full and
// pop while empty are dropped internally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == LVL_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with TX FIFO; data width, parity and stop length are
// sampled when a byte leaves the FIFO and held for that whole frame.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 8,
   parameter int OVERSAMPLE    = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_sample_tick,
   input  logic [$clog2(MAX_DATA_BITS+1)-1:0]  i_cfg_data_bits,
   input  logic [1:0]                          i_cfg_parity,
   input  logic [1:0]                          i_cfg_stop,
   input  logic                                i_tx_valid,
   input  logic [MAX_DATA_BITS-1:0]            i_tx_data,
   output logic                                o_tx_ready,
   output logic                                o_tx,
   output logic                                o_tx_busy,
   output logic                                o_tx_done_tick,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_level
);

   localparam int DB_W  = $clog2(MAX_DATA_BITS + 1);
   localparam int CNT_W = $clog2(2 * OVERSAMPLE);
   localparam logic [CNT_W-1:0] BIT_END = CNT_W'(OVERSAMPLE - 1);

   state_t                   state;
   logic [CNT_W-1:0]         tick_cnt;
   logic [CNT_W-1:0]         stop_end;
   logic [MAX_DATA_BITS-1:0] shift;
   logic [DB_W-1:0]          bit_idx;
   logic [DB_W-1:0]          bits_lat;
   logic                     par_en;
   logic                     par_odd;
   logic                     par_acc;
   logic                     tx_reg;
   logic                     done_reg;

   logic [MAX_DATA_BITS-1:0] fifo_head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic                     stop_done;
   logic [DB_W-1:0]          eff_bits;
   logic                     cfg_par_en;
   logic                     cfg_par_odd;

   sync_fifo #(
      .WIDTH (MAX_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (i_tx_valid),
      .push_data (i_tx_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (o_fifo_level)
   );

   assign eff_bits = (i_cfg_data_bits < DB_W'(5) || i_cfg_data_bits > DB_W'(MAX_DATA_BITS))
                   ? DB_W'(MAX_DATA_BITS) : i_cfg_data_bits;

   always_comb begin
      cfg_par_en  = 1'b0;
      cfg_par_odd = 1'b0;
      case (i_cfg_parity)
         PAR_NONE: cfg_par_en = 1'b0;
         PAR_EVEN: cfg_par_en = 1'b1;
         PAR_ODD: begin
            cfg_par_en  = 1'b1;
            cfg_par_odd = 1'b1;
         end
         default:  cfg_par_en = 1'b0;
      endcase
   end

   // A new frame is loaded either from IDLE or on the last stop tick, so
   // consecutive frames leave no idle gap on the line.
   assign stop_done = (state == S_STOP) && i_sample_tick && (tick_cnt == stop_end);
   assign pop       = ~fifo_empty && ((state == S_IDLE) || stop_done);

   assign o_tx_ready     = ~fifo_full;
   assign o_tx           = tx_reg;
   assign o_tx_busy      = (state != S_IDLE);
   assign o_tx_done_tick = done_reg;

   // tx_reg always takes the line level of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         stop_end <= '0;
         shift    <= '0;
         bit_idx  <= '0;
         bits_lat <= '0;
         par_en   <= 1'b0;
         par_odd  <= 1'b0;
         par_acc  <= 1'b0;
         tx_reg   <= 1'b1;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            S_IDLE: tx_reg <= 1'b1;
            S_START: begin
               if (i_sample_tick) begin
                  if (tick_cnt == BIT_END) begin
                     tick_cnt <= '0;
                     state    <= S_DATA;
                     tx_reg   <= shift[0];
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
            end
            S_DATA: begin
               if (i_sample_tick) begin
                  if (tick_cnt == BIT_END) begin
                     tick_cnt <= '0;
                     shift    <= shift >> 1;
                     par_acc  <= par_acc ^ shift[0];
                     bit_idx  <= bit_idx + DB_W'(1);
                     if (bit_idx == bits_lat - DB_W'(1)) begin
                        if (par_en) begin
                           state  <= S_PARITY;
                           tx_reg <= par_acc ^ shift[0] ^ par_odd;
                        end else begin
                           state  <= S_STOP;
                           tx_reg <= 1'b1;
                        end
                     end else begin
                        tx_reg <= shift[1];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (i_sample_tick) begin
                  if (tick_cnt == BIT_END) begin
                     tick_cnt <= '0;
                     state    <= S_STOP;
                     tx_reg   <= 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
            end
            S_STOP: begin
               if (i_sample_tick) begin
                  if (tick_cnt == stop_end) begin
                     tick_cnt <= '0;
                     done_reg <= 1'b1;
                     state    <= S_IDLE;
                     tx_reg   <= 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               tx_reg <= 1'b1;
            end
         endcase

         if (pop) begin
            state    <= S_START;
            tx_reg   <= 1'b0;
            tick_cnt <= '0;
            shift    <= fifo_head;
            bit_idx  <= '0;
            bits_lat <= eff_bits;
            par_en   <= cfg_par_en;
            par_odd  <= cfg_par_odd;
            par_acc  <= 1'b0;
            stop_end <= CNT_W'(stop_ticks(i_cfg_stop, OVERSAMPLE) - 1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: the serial line is sampled on every tick
// while busy and compared against hand-derived frame waveforms.
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_sample_tick;
   logic [3:0] i_cfg_data_bits;
   logic [1:0] i_cfg_parity;
   logic [1:0] i_cfg_stop;
   logic       i_tx_valid;
   logic [7:0] i_tx_data;
   logic       o_tx_ready;
   logic       o_tx;
   logic       o_tx_busy;
   logic       o_tx_done_tick;
   logic [2:0] o_fifo_level;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [4095:0] line_vec;
   logic [4095:0] exp_vec;
   int            line_n   = 0;
   int            exp_n    = 0;
   int            done_cnt = 0;

   uart_tx_cfg #(
      .MAX_DATA_BITS (8),
      .OVERSAMPLE    (16),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_sample_tick   (i_sample_tick),
      .i_cfg_data_bits (i_cfg_data_bits),
      .i_cfg_parity    (i_cfg_parity),
      .i_cfg_stop      (i_cfg_stop),
      .i_tx_valid      (i_tx_valid),
      .i_tx_data       (i_tx_data),
      .o_tx_ready      (o_tx_ready),
      .o_tx            (o_tx),
      .o_tx_busy       (o_tx_busy),
      .o_tx_done_tick  (o_tx_done_tick),
      .o_fifo_level    (o_fifo_level)
   );

   always #5 clk = ~clk;

   // Sample tick every second clock, changed just after the rising edge.
   initial begin
      i_sample_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         i_sample_tick = ~i_sample_tick;
      end
   end

   always @(negedge clk) begin
      if (o_tx_busy && i_sample_tick) begin
         line_vec[line_n] = o_tx;
         line_n++;
      end
      if (o_tx_done_tick) done_cnt++;
   end

   function automatic int line_diff(input int base);
      int got_n;
      got_n = line_n - base;
      if (got_n != exp_n) return (got_n < exp_n) ? got_n : exp_n;
      for (int i = 0; i < exp_n; i++) begin
         if (line_vec[base + i] !== exp_vec[i]) return i;
      end
      return -1;
   endfunction

   task automatic exp_seg(input logic lvl, input int ticks);
      for (int i = 0; i < ticks; i++) begin
         exp_vec[exp_n] = lvl;
         exp_n++;
      end
   endtask

   task automatic exp_frame(input logic [7:0] data, input int nbits,
                            input logic [1:0] par, input int stop_len);
      logic p;
      p = 1'b0;
      exp_seg(1'b0, 16);
      for (int i = 0; i < nbits; i++) begin
         exp_seg(data[i], 16);
         p = p ^ data[i];
      end
      if (par == 2'b01) exp_seg(p, 16);
      else if (par == 2'b10) exp_seg(~p, 16);
      exp_seg(1'b1, stop_len);
   endtask

   task automatic set_cfg(input logic [3:0] bits, input logic [1:0] par, input logic [1:0] stop);
      i_cfg_data_bits = bits;
      i_cfg_parity    = par;
      i_cfg_stop      = stop;
   endtask

   task automatic push_byte(input logic [7:0] data);
      @(posedge clk);
      #1;
      i_tx_valid = 1'b1;
      i_tx_data  = data;
      @(posedge clk);
      #1;
      i_tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      bit timed_out;
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         #1;
         if (!o_tx_busy && o_fifo_level == 3'd0) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (timed_out) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s_timeout: busy=%0b level=%0d after %0d cycles, need idle", name, o_tx_busy, o_fifo_level, max_cyc);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (o_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tx: got %b need 1", o_tx); end
      tests_run++;
      if (o_tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b need 1", o_tx_ready); end
      tests_run++;
      if (o_tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b need 0", o_tx_busy); end
      tests_run++;
      if (o_tx_done_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b need 0", o_tx_done_tick); end
      tests_run++;
      if (o_fifo_level !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d need 0", o_fifo_level); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_8n1();
      int lbase, dbase, d;
      logic [9:0] pat;
      set_cfg(4'd8, 2'b00, 2'b00);
      exp_n = 0;
      pat = 10'b1101001010;
      for (int i = 0; i < 10; i++) exp_seg(pat[i], 16);
      lbase = line_n;
      dbase = done_cnt;
      push_byte(8'hA5);
      tests_run++;
      if (o_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL 8n1_tx_after_push: got %b need 1", o_tx); end
      tests_run++;
      if (o_fifo_level !== 3'd1) begin tests_failed++; $display("[TB] FAIL 8n1_level_after_push: got %0d need 1", o_fifo_level); end
      @(posedge clk);
      #1;
      tests_run++;
      if (o_tx !== 1'b0) begin tests_failed++; $display("[TB] FAIL 8n1_tx_after_pop: got %b need 0", o_tx); end
      tests_run++;
      if (o_tx_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL 8n1_busy_after_pop: got %b need 1", o_tx_busy); end
      tests_run++;
      if (o_fifo_level !== 3'd0) begin tests_failed++; $display("[TB] FAIL 8n1_level_after_pop: got %0d need 0", o_fifo_level); end
      wait_idle(1000, "8n1");
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL 8n1_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 1) begin tests_failed++; $display("[TB] FAIL 8n1_done: got %0d pulses need 1", done_cnt - dbase); end
   endtask

   task automatic test_7e2();
      int lbase, dbase, d;
      logic [8:0] pat;
      set_cfg(4'd7, 2'b01, 2'b10);
      exp_n = 0;
      pat = 9'b010101010;
      for (int i = 0; i < 9; i++) exp_seg(pat[i], 16);
      exp_seg(1'b1, 32);
      lbase = line_n;
      dbase = done_cnt;
      push_byte(8'h55);
      wait_idle(1000, "7e2");
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL 7e2_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 1) begin tests_failed++; $display("[TB] FAIL 7e2_done: got %0d pulses need 1", done_cnt - dbase); end
   endtask

   task automatic test_5o15();
      int lbase, dbase, d;
      logic [6:0] pat;
      set_cfg(4'd5, 2'b10, 2'b01);
      exp_n = 0;
      pat = 7'b0111110;
      for (int i = 0; i < 7; i++) exp_seg(pat[i], 16);
      exp_seg(1'b1, 24);
      lbase = line_n;
      dbase = done_cnt;
      push_byte(8'h1F);
      wait_idle(1000, "5o15");
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL 5o15_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 1) begin tests_failed++; $display("[TB] FAIL 5o15_done: got %0d pulses need 1", done_cnt - dbase); end
   endtask

   task automatic test_bad_bits();
      int lbase, dbase, d;
      set_cfg(4'd3, 2'b00, 2'b11);
      exp_n = 0;
      exp_frame(8'h5A, 8, 2'b00, 16);
      exp_frame(8'hC1, 8, 2'b00, 16);
      lbase = line_n;
      dbase = done_cnt;
      push_byte(8'h5A);
      wait_idle(1000, "bad_bits_lo");
      set_cfg(4'd12, 2'b11, 2'b00);
      push_byte(8'hC1);
      wait_idle(1000, "bad_bits_hi");
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL bad_bits_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 2) begin tests_failed++; $display("[TB] FAIL bad_bits_done: got %0d pulses need 2", done_cnt - dbase); end
   endtask

   task automatic test_back_to_back();
      int lbase, dbase, d, dn, gaps;
      logic [7:0] burst [5];
      burst = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E};
      set_cfg(4'd8, 2'b00, 2'b00);
      exp_n = 0;
      for (int i = 0; i < 5; i++) exp_frame(burst[i], 8, 2'b00, 16);
      lbase = line_n;
      dbase = done_cnt;
      @(posedge clk);
      #1;
      i_tx_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_tx_data = (i < 5) ? burst[i] : 8'hFF;
         @(posedge clk);
         #1;
      end
      i_tx_valid = 1'b0;
      tests_run++;
      if (o_fifo_level !== 3'd4) begin tests_failed++; $display("[TB] FAIL b2b_level_full: got %0d need 4", o_fifo_level); end
      tests_run++;
      if (o_tx_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ready_full: got %b need 0", o_tx_ready); end
      dn = 0;
      gaps = 0;
      for (int i = 0; i < 4000 && dn < 5; i++) begin
         @(negedge clk);
         if (o_tx_done_tick) dn++;
         else if (!o_tx_busy) gaps++;
      end
      wait_idle(1000, "b2b");
      tests_run++;
      if (gaps != 0) begin tests_failed++; $display("[TB] FAIL b2b_gaps: got %0d idle cycles need 0", gaps); end
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL b2b_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 5) begin tests_failed++; $display("[TB] FAIL b2b_done: got %0d pulses need 5", done_cnt - dbase); end
   endtask

   task automatic test_cfg_change();
      int lbase, dbase, d;
      set_cfg(4'd8, 2'b00, 2'b00);
      exp_n = 0;
      exp_frame(8'h96, 8, 2'b00, 16);
      exp_frame(8'h2B, 7, 2'b10, 32);
      lbase = line_n;
      dbase = done_cnt;
      push_byte(8'h96);
      push_byte(8'h2B);
      repeat (30) @(posedge clk);
      #1;
      set_cfg(4'd7, 2'b10, 2'b10);
      wait_idle(2000, "cfg_change");
      d = line_diff(lbase);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("[TB] FAIL cfg_change_line: got %0d samples need %0d, first diff at %0d", line_n - lbase, exp_n, d); end
      tests_run++;
      if (done_cnt - dbase != 2) begin tests_failed++; $display("[TB] FAIL cfg_change_done: got %0d pulses need 2", done_cnt - dbase); end
   endtask

   task automatic test_reset_mid();
      int dbase, lows, busys;
      set_cfg(4'd8, 2'b00, 2'b00);
      dbase = done_cnt;
      @(posedge clk);
      #1;
      i_tx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_tx_data = 8'h10 + 8'(i);
         @(posedge clk);
         #1;
      end
      i_tx_valid = 1'b0;
      tests_run++;
      if (o_fifo_level !== 3'd3) begin tests_failed++; $display("[TB] FAIL midrst_level_before: got %0d need 3", o_fifo_level); end
      repeat (80) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (o_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_tx: got %b need 1", o_tx); end
      tests_run++;
      if (o_fifo_level !== 3'd0) begin tests_failed++; $display("[TB] FAIL midrst_level: got %0d need 0", o_fifo_level); end
      tests_run++;
      if (o_tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy: got %b need 0", o_tx_busy); end
      tests_run++;
      if (o_tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_ready: got %b need 1", o_tx_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lows = 0;
      busys = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (o_tx !== 1'b1) lows++;
         if (o_tx_busy !== 1'b0) busys++;
      end
      tests_run++;
      if (lows != 0 || busys != 0) begin tests_failed++; $display("[TB] FAIL midrst_quiet: got %0d low and %0d busy cycles need 0", lows, busys); end
      tests_run++;
      if (done_cnt - dbase != 0) begin tests_failed++; $display("[TB] FAIL midrst_done: got %0d pulses need 0", done_cnt - dbase); end
   endtask

   initial begin
      rst_n      = 1'b0;
      i_tx_valid = 1'b0;
      i_tx_data  = 8'h00;
      set_cfg(4'd8, 2'b00, 2'b00);
      test_reset();
      test_8n1();
      test_7e2();
      test_5o15();
      test_bad_bits();
      test_back_to_back();
      test_cfg_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
